// File: rtl/ldw_regwb_arbiter_pkg.sv
// Shared widths and helpers for the register-file write-back arbiter and its scoreboard.
package ldw_regwb_arbiter_pkg;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;
    localparam int WCW   = 4;   // wide enough for MAXWAIT up to 15

    localparam logic [AW-1:0] REG_ZERO = '0;

    function automatic logic [NREGS-1:0] reg_onehot(input logic [AW-1:0] wn);
        logic [NREGS-1:0] one;
        one = {{(NREGS-1){1'b0}}, 1'b1};
        return one << wn;
    endfunction

endpackage

// File: rtl/ldw_regwb_arbiter_if.sv
// Write-back request, issue/hazard query and register-file write-port signals of the arbiter.
interface ldw_regwb_arbiter_if;
    import ldw_regwb_arbiter_pkg::*;

    logic          p_valid;
    logic [AW-1:0] p_wn;
    logic [DW-1:0] p_d;
    logic          p_ready;

    logic          s_valid;
    logic [AW-1:0] s_wn;
    logic [DW-1:0] s_d;
    logic          s_ready;

    logic          s_issue;
    logic [AW-1:0] s_issue_wn;
    logic          s_issue_ok;

    logic [AW-1:0] chk_a;
    logic [AW-1:0] chk_b;
    logic          hazard_a;
    logic          hazard_b;

    logic          rf_we;
    logic [AW-1:0] rf_wn;
    logic [DW-1:0] rf_d;

    modport slave (
        input  p_valid, p_wn, p_d, s_valid, s_wn, s_d, s_issue, s_issue_wn, chk_a, chk_b,
        output p_ready, s_ready, s_issue_ok, hazard_a, hazard_b, rf_we, rf_wn, rf_d
    );

    modport master (
        output p_valid, p_wn, p_d, s_valid, s_wn, s_d, s_issue, s_issue_wn, chk_a, chk_b,
        input  p_ready, s_ready, s_issue_ok, hazard_a, hazard_b, rf_we, rf_wn, rf_d
    );

endinterface

// File: rtl/ldw_wb_scoreboard.sv
// Pending-write bitmap for multicycle results: WAW issue gating and RAW hazard lookups.
module ldw_wb_scoreboard
    import ldw_regwb_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          clr,
    input  logic          set_en,
    input  logic [AW-1:0] set_wn,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_wn,
    input  logic [AW-1:0] chk_a,
    input  logic [AW-1:0] chk_b,
    input  logic          wr_we,
    input  logic [AW-1:0] wr_wn,
    output logic          issue_ok,
    output logic          hazard_a,
    output logic          hazard_b
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    always_comb begin
        issue_ok = ~pend_q[set_wn];
        set_vec  = '0;
        clr_vec  = '0;
        if (set_en && issue_ok && set_wn != REG_ZERO)
            set_vec = reg_onehot(set_wn);
        if (clr_en)
            clr_vec = reg_onehot(clr_wn);
    end

    // A set beats a clear on the same register: the new issue follows the completion.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pend_d[gi] = 1'b0;
            end else begin : g_bit
                assign pend_d[gi] = set_vec[gi] | (pend_q[gi] & ~clr_vec[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr)
            pend_q <= '0;
        else
            pend_q <= pend_d;
    end

    // The write-port term covers a result registered but not yet committed to the file.
    always_comb begin
        hazard_a = (chk_a != REG_ZERO) && (pend_q[chk_a] || (wr_we && wr_wn == chk_a));
        hazard_b = (chk_b != REG_ZERO) && (pend_q[chk_b] || (wr_we && wr_wn == chk_b));
    end

endmodule

// File: rtl/ldw_regwb_arbiter.sv
// Shares the single register-file write port between pipeline write-back and a multicycle unit.
module ldw_regwb_arbiter
    import ldw_regwb_arbiter_pkg::*;
#(
    parameter int MAXWAIT = 4
)(
    input  logic                 clk,
    input  logic                 clr,
    ldw_regwb_arbiter_if.slave   wb
);

    localparam logic [WCW-1:0] MAXW = WCW'(MAXWAIT);

    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           rf_we_q, rf_we_d;
    logic [AW-1:0]  rf_wn_q, rf_wn_d;
    logic [DW-1:0]  rf_d_q, rf_d_d;

    logic           force_grant;
    logic           p_grant;
    logic           s_grant;
    logic           any_grant;
    logic [AW-1:0]  g_wn;
    logic [DW-1:0]  g_data;

    // Primary wins by default; a secondary that has lost MAXWAIT cycles in a row is forced through.
    always_comb begin
        force_grant = (wait_cnt_q == MAXW);
        s_grant     = wb.s_valid & (force_grant | ~wb.p_valid) & ~clr;
        p_grant     = wb.p_valid & ~(force_grant & wb.s_valid) & ~clr;
        any_grant   = p_grant | s_grant;
        g_wn        = s_grant ? wb.s_wn : wb.p_wn;
        g_data      = s_grant ? wb.s_d  : wb.p_d;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!wb.s_valid || s_grant)
            wait_cnt_d = '0;
        else if (wait_cnt_q != MAXW)
            wait_cnt_d = wait_cnt_q + 1'b1;

        rf_we_d = any_grant && (g_wn != REG_ZERO);
        rf_wn_d = any_grant ? g_wn   : rf_wn_q;
        rf_d_d  = any_grant ? g_data : rf_d_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_wn_q    <= '0;
            rf_d_q     <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_wn_q    <= rf_wn_d;
            rf_d_q     <= rf_d_d;
        end
    end

    logic sb_issue_ok, sb_hazard_a, sb_hazard_b;

    ldw_wb_scoreboard u_scoreboard (
        .clk      (clk),
        .clr      (clr),
        .set_en   (wb.s_issue),
        .set_wn   (wb.s_issue_wn),
        .clr_en   (s_grant),
        .clr_wn   (wb.s_wn),
        .chk_a    (wb.chk_a),
        .chk_b    (wb.chk_b),
        .wr_we    (rf_we_q),
        .wr_wn    (rf_wn_q),
        .issue_ok (sb_issue_ok),
        .hazard_a (sb_hazard_a),
        .hazard_b (sb_hazard_b)
    );

    assign wb.p_ready    = p_grant;
    assign wb.s_ready    = s_grant;
    assign wb.s_issue_ok = sb_issue_ok;
    assign wb.hazard_a   = sb_hazard_a;
    assign wb.hazard_b   = sb_hazard_b;
    assign wb.rf_we      = rf_we_q;
    assign wb.rf_wn      = rf_wn_q;
    assign wb.rf_d       = rf_d_q;

endmodule

// File: tb/tb_ldw_regwb_arbiter.sv
// Directed and random checks of the write-back arbiter against a queue-free reference model.
module tb_ldw_regwb_arbiter;
    import ldw_regwb_arbiter_pkg::*;

    localparam int MAXWAIT = 4;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    ldw_regwb_arbiter_if bus ();

    ldw_regwb_arbiter #(.MAXWAIT(MAXWAIT)) dut (
        .clk (clk),
        .clr (clr),
        .wb  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_pend [NREGS];
    int          m_lost;
    bit          m_we;
    int unsigned m_wn;
    logic [31:0] m_d;
    bit          last_p, last_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_lost = 0;
        m_we   = 1'b0;
        m_wn   = 0;
        m_d    = '0;
    endtask

    task automatic idle();
        bus.p_valid = 0; bus.p_wn = '0; bus.p_d = '0;
        bus.s_valid = 0; bus.s_wn = '0; bus.s_d = '0;
        bus.s_issue = 0; bus.s_issue_wn = '0;
        bus.chk_a = '0; bus.chk_b = '0;
    endtask

    function automatic bit hz(input int unsigned r);
        return (r != 0) && (m_pend[r] || (m_we && m_wn == r));
    endfunction

    // One clock: check combinational outputs, advance the model over the edge, check the write port.
    task automatic cyc(input string tag);
        bit starved, exp_s, exp_p, exp_ok;
        int unsigned wn, iwn;
        logic [31:0] d;
        #1;
        starved = (m_lost >= MAXWAIT);
        exp_s   = !clr && bus.s_valid && (starved || !bus.p_valid);
        exp_p   = !clr && bus.p_valid && !(starved && bus.s_valid);
        iwn     = int'(bus.s_issue_wn);
        exp_ok  = !m_pend[iwn];
        chk({tag, ".p_ready"},  {31'b0, bus.p_ready},    {31'b0, exp_p});
        chk({tag, ".s_ready"},  {31'b0, bus.s_ready},    {31'b0, exp_s});
        chk({tag, ".issue_ok"}, {31'b0, bus.s_issue_ok}, {31'b0, exp_ok});
        chk({tag, ".hazard_a"}, {31'b0, bus.hazard_a},   {31'b0, hz(int'(bus.chk_a))});
        chk({tag, ".hazard_b"}, {31'b0, bus.hazard_b},   {31'b0, hz(int'(bus.chk_b))});
        last_p = exp_p;
        last_s = exp_s;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            if (exp_s) m_pend[int'(bus.s_wn)] = 1'b0;
            if (bus.s_issue && exp_ok && iwn != 0) m_pend[iwn] = 1'b1;
            if (exp_s || exp_p) begin
                wn   = exp_s ? int'(bus.s_wn) : int'(bus.p_wn);
                d    = exp_s ? bus.s_d : bus.p_d;
                m_we = (wn != 0);
                m_wn = wn;
                m_d  = d;
            end else begin
                m_we = 1'b0;
            end
            if (!bus.s_valid || exp_s) m_lost = 0;
            else if (m_lost < MAXWAIT) m_lost++;
        end
        #1;
        chk({tag, ".rf_we"}, {31'b0, bus.rf_we}, {31'b0, m_we});
        chk({tag, ".rf_wn"}, {27'b0, bus.rf_wn}, m_wn);
        chk({tag, ".rf_d"},  bus.rf_d,           m_d);
        $display("cyc %-10s p=%0b s=%0b we=%0b wn=%0d d=%h", tag, last_p, last_s, bus.rf_we, bus.rf_wn, bus.rf_d);
    endtask

    initial begin
        int first_s;
        idle();
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset with every request active
        bus.p_valid = 1; bus.p_wn = 5'd4; bus.p_d = 32'h1111_2222;
        bus.s_valid = 1; bus.s_wn = 5'd5; bus.s_d = 32'h3333_4444;
        bus.s_issue = 1; bus.s_issue_wn = 5'd5; bus.chk_a = 5'd5; bus.chk_b = 5'd4;
        cyc("reset0");
        cyc("reset1");
        chk("reset.rf_we", {31'b0, bus.rf_we}, 32'd0);
        chk("reset.hazard_a", {31'b0, bus.hazard_a}, 32'd0);
        idle();
        clr = 1'b0;
        cyc("idle");

        // Single primary write and its one-cycle hazard window
        bus.p_valid = 1; bus.p_wn = 5'd3; bus.p_d = 32'hDEAD_BEEF; bus.chk_a = 5'd3;
        cyc("prim");
        chk("prim.rf_d", bus.rf_d, 32'hDEAD_BEEF);
        chk("prim.hz_window", {31'b0, bus.hazard_a}, 32'd1);
        bus.p_valid = 0;
        cyc("prim_hz");
        chk("prim.hz_gone", {31'b0, bus.hazard_a}, 32'd0);

        // Starvation: secondary forced through on the fifth contended cycle
        bus.p_valid = 1; bus.s_valid = 1; bus.s_wn = 5'd12; bus.s_d = 32'h5EC0_0001;
        first_s = -1;
        for (int i = 0; i < 7; i++) begin
            bus.p_wn = 5'(20 + i); bus.p_d = 32'hA000_0000 + i;
            cyc("starve");
            if (last_s && first_s < 0) first_s = i;
        end
        chk("starve.first_s", first_s, 32'd4);
        idle();
        cyc("idle");

        // Scoreboard set, WAW block, clear, rf_we tail
        bus.s_issue = 1; bus.s_issue_wn = 5'd7;
        cyc("issue7");
        bus.chk_b = 5'd7;
        cyc("issue7b");
        chk("sb.hazard_b", {31'b0, bus.hazard_b}, 32'd1);
        chk("sb.waw_block", {31'b0, bus.s_issue_ok}, 32'd0);
        bus.s_issue = 0;
        bus.s_valid = 1; bus.s_wn = 5'd7; bus.s_d = 32'h0000_0777;
        cyc("wr7");
        chk("sb.tail", {31'b0, bus.hazard_b}, 32'd1);
        bus.s_valid = 0;
        cyc("tail7");
        chk("sb.clear", {31'b0, bus.hazard_b}, 32'd0);

        // Set and clear of r9 in the same cycle: set wins
        bus.s_issue = 1; bus.s_issue_wn = 5'd9; bus.chk_b = 5'd9;
        cyc("issue9");
        bus.s_issue = 0; bus.s_valid = 1; bus.s_wn = 5'd9; bus.s_d = 32'h9999_0001;
        cyc("wr9a");
        bus.s_issue = 1; bus.s_d = 32'h9999_0002;
        cyc("wr9set");
        idle(); bus.chk_b = 5'd9;
        cyc("hold9");
        cyc("hold9b");
        chk("setwins.hazard_b", {31'b0, bus.hazard_b}, 32'd1);

        // r0: handshake completes, nothing written, never pending
        idle();
        bus.p_valid = 1; bus.p_wn = 5'd0; bus.p_d = 32'hFFFF_FFFF;
        cyc("r0p");
        chk("r0.p_granted", {31'b0, last_p}, 32'd1);
        chk("r0.rf_we", {31'b0, bus.rf_we}, 32'd0);
        idle();
        bus.s_issue = 1; bus.s_issue_wn = 5'd0;
        cyc("r0issue");
        bus.s_issue = 0; bus.chk_a = 5'd0;
        cyc("r0chk");
        chk("r0.hazard_a", {31'b0, bus.hazard_a}, 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            clr            = ($urandom_range(0, 49) == 0);
            bus.p_valid    = $urandom_range(0, 1);
            bus.p_wn       = 5'($urandom_range(0, 7));
            bus.p_d        = $urandom;
            bus.s_valid    = ($urandom_range(0, 2) != 0);
            bus.s_wn       = 5'($urandom_range(0, 7));
            bus.s_d        = $urandom;
            bus.s_issue    = ($urandom_range(0, 2) == 0);
            bus.s_issue_wn = 5'($urandom_range(0, 7));
            bus.chk_a      = 5'($urandom_range(0, 7));
            bus.chk_b      = 5'($urandom_range(0, 31));
            cyc("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldw_regwb_arbiter.md
Name: ldw_regwb_arbiter

Overview:
Write-back arbiter and scoreboard for the 32x32 register file, which has a single write port (r0 hard-wired to zero).
- Shares that port between two requesters: the primary pipeline write-back and a secondary multicycle unit (mul/div/load).
- Tracks registers with outstanding multicycle writes so issue logic can stall on RAW/WAW hazards.
- Sits between the write-back stage and the register file's write port (we/wn/d).

Parameters:
DW, 32, data width
AW, 5, register index width (32 registers)
MAXWAIT, 4, consecutive lost cycles after which the secondary requester is forced a grant (1..15)

Ports:
clk  in  1  clock, all state on rising edge
clr  in  1  synchronous active-high reset
p_valid  in  1  primary write request
p_wn  in  AW  primary destination register
p_d  in  DW  primary write data
p_ready  out  1  primary accepted this cycle (combinational)
s_valid  in  1  secondary write request
s_wn  in  AW  secondary destination register
s_d  in  DW  secondary write data
s_ready  out  1  secondary accepted this cycle (combinational)
s_issue  in  1  multicycle op issued, marks destination pending
s_issue_wn  in  AW  destination of issued op
s_issue_ok  out  1  issue allowed (destination not already pending)
chk_a  in  AW  source register A queried by issue logic
chk_b  in  AW  source register B queried by issue logic
hazard_a  out  1  chk_a unsafe to read this cycle
hazard_b  out  1  chk_b unsafe to read this cycle
rf_we  out  1  register file write enable (registered)
rf_wn  out  AW  register file write index (registered)
rf_d  out  DW  register file write data (registered)

Behaviour:
Reset and registered outputs
- clr=1 at a rising edge: rf_we=0, rf_wn=0, rf_d=0, pending bitmap pend[31:0]=0, wait_cnt=0.
- While clr=1, p_ready=0 and s_ready=0 combinationally. Reset mid-transfer drops the in-flight write.

Arbitration (combinational, per cycle)
- force = (wait_cnt == MAXWAIT).
- s_ready = s_valid & (force | ~p_valid) & ~clr.
- p_ready = p_valid & ~(force & s_valid) & ~clr.
- At most one grant per cycle. Primary has default priority.

Starvation counter
- Increments when s_valid & ~s_ready, saturating at MAXWAIT.
- Clears to 0 on a secondary grant or when s_valid=0.

Write-port register
- On a grant at edge N, rf_we/rf_wn/rf_d present that request during cycle N+1. The register file commits it at edge N+1, giving 1-cycle latency.
- A granted request with wn==0 completes its handshake, but rf_we is 0.
- No grant: rf_we=0; rf_wn and rf_d hold their previous values.

Scoreboard
- set: s_issue & s_issue_ok & s_issue_wn!=0 sets pend[s_issue_wn].
- clear: a secondary grant clears pend[s_wn].
- Same register set and cleared in the same cycle: set wins, since a new issue follows the completion.
- pend[0] is always 0.
- s_issue_ok = ~pend[s_issue_wn] (WAW stall). s_issue while ~s_issue_ok is ignored.

Hazards
- hazard_x = (chk_x!=0) & (pend[chk_x] | (rf_we & rf_wn==chk_x)).
- The second term covers a write that is registered but not yet committed.
- chk_x==0 never reports a hazard.

Ordering
- A primary write to a pending register is legal at the port level. Issue logic prevents it via hazard_x; the arbiter does not check it.

Decomposition:
- Shared package: DW, AW, NREGS=32, REG_ZERO=0.
- One natural sub-module, ldw_wb_scoreboard: pend bitmap, set/clear logic, s_issue_ok, hazard_a/hazard_b lookups.
- The arbiter top holds the grant logic, wait_cnt and the write-port register.

Test Plan:
- Reset: assert clr with all inputs active -> p_ready=0, s_ready=0, rf_we=0 next cycle, hazard_a=0 for chk_a=5.
- Single primary: p_valid=1, p_wn=3, p_d=0xDEADBEEF at edge N -> rf_we=1, rf_wn=3, rf_d=0xDEADBEEF in cycle N+1; hazard_a=1 for chk_a=3 in cycle N+1 only.
- Starvation: p_valid and s_valid held high, MAXWAIT=4 -> primary granted 4 cycles, secondary granted on the 5th with p_ready=0, then wait_cnt=0 and primary resumes.
- Scoreboard: s_issue with s_issue_wn=7 -> hazard_b=1 for chk_b=7 and s_issue_ok=0 for a second issue to 7. Secondary write to 7 -> pend clears at the grant edge, hazard stays 1 for one more cycle (rf_we term), then 0.
- Simultaneous set/clear: secondary grant to r9 in the same cycle as s_issue to r9 (pend[9] already 1 makes s_issue_ok=0, so first clear it, then issue while a second request to r9 completes) -> pend[9]=1 after the edge.
- r0 writes: p_wn=0 granted -> p_ready=1, rf_we=0. s_issue_wn=0 -> pend unchanged, hazard_a=0 for chk_a=0.
